// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared types and lane helpers for the data-memory responder.
//   size_e       - access size encoding carried on SIZE
//   dmr_state_e  - responder FSM states
//   helpers      - alignment fault, byte-enable, store lane replication, load extraction
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    SizeByte    = 2'b00,
    SizeHalf    = 2'b01,
    SizeWord    = 2'b10,
    SizeIllegal = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    DmrIdle = 2'b00,
    DmrWait = 2'b01,
    DmrResp = 2'b10
  } dmr_state_e;

  localparam int unsigned DefaultWaitCycles = 2;

  // Fault when the access is not naturally aligned or the size is illegal.
  function automatic logic is_misaligned(size_e size, logic [1:0] lane);
    logic f;
    case (size)
      SizeByte: f = 1'b0;
      SizeHalf: f = lane[0];
      SizeWord: f = |lane;
      default:  f = 1'b1;
    endcase
    return f;
  endfunction

  function automatic logic [3:0] store_be(size_e size, logic [1:0] lane);
    logic [3:0] be;
    case (size)
      SizeByte: be = 4'b0001 << lane;
      SizeHalf: be = lane[1] ? 4'b1100 : 4'b0011;
      SizeWord: be = 4'b1111;
      default:  be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate the right-aligned store data across lanes; the byte enables pick the target.
  function automatic logic [31:0] store_data(size_e size, logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      SizeByte: d = {4{wdata[7:0]}};
      SizeHalf: d = {2{wdata[15:0]}};
      default:  d = wdata;
    endcase
    return d;
  endfunction

  // Shift the selected lane(s) down to bit 0 and zero-extend.
  function automatic logic [31:0] load_extract(size_e size, logic [1:0] lane, logic [31:0] word);
    logic [31:0] sh;
    logic [31:0] d;
    sh = word >> {lane, 3'b000};
    case (size)
      SizeByte: d = {24'h0, sh[7:0]};
      SizeHalf: d = {16'h0, sh[15:0]};
      SizeWord: d = word;
      default:  d = 32'h0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: load/store request bus between the core (master) and the responder (slave).
//   MREQ/WRITE/SIZE/addr/wdata - request, held by the master until ready
//   rdata/ready/err/busy       - response, ready is a one-cycle pulse
interface dmem_responder_if;
  logic        MREQ;
  logic        WRITE;
  logic [1:0]  SIZE;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        busy;

  modport master (
    output MREQ, WRITE, SIZE, addr, wdata,
    input  rdata, ready, err, busy
  );

  modport slave (
    input  MREQ, WRITE, SIZE, addr, wdata,
    output rdata, ready, err, busy
  );
endinterface

// File: rtl/dmem_responder_array.sv
// dmem_responder_array: 2**ADDR_WIDTH x 32 word RAM, synchronous byte-enable write,
// asynchronous read, no reset.
//   clk     - write clock
//   i_we    - write strobe
//   i_be    - per-byte write enables (bit n covers [8n+7:8n])
//   i_addr  - word index
//   i_wdata - write data (already lane-aligned)
//   o_rdata - word at i_addr
module dmem_responder_array #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [3:0]            i_be,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata
);

  logic [31:0] r_mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we && i_be[b]) begin
        r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: slave end of the core's load/store bus. Captures a request, waits
// WAIT_CYCLES, then performs a byte/half/word access on the internal RAM and pulses ready.
//   clk - clock, rising edge
//   rst - asynchronous active-low reset
//   bus - dmem_responder_if slave modport (request in, rdata/ready/err/busy out)
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = DefaultWaitCycles
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);

  localparam int unsigned CntW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

  dmr_state_e            r_state;
  logic [CntW-1:0]       r_cnt;
  logic                  r_write;
  size_e                 r_size;
  logic [ADDR_WIDTH+1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rdata;
  logic                  r_ready;
  logic                  r_err;
  logic                  r_busy;

  logic [ADDR_WIDTH-1:0] w_word_idx;
  logic [1:0]            w_lane;
  logic                  w_fault;
  logic                  w_we;
  logic [3:0]            w_be;
  logic [31:0]           w_wr_data;
  logic [31:0]           w_rd_word;
  logic [31:0]           w_load_data;
  logic                  w_unused_addr;

  // Upper address bits alias onto the RAM; only the word index and lane are kept.
  assign w_unused_addr = ^bus.addr[31:ADDR_WIDTH+2];

  assign w_word_idx  = r_addr[ADDR_WIDTH+1:2];
  assign w_lane      = r_addr[1:0];
  assign w_fault     = is_misaligned(r_size, w_lane);
  assign w_be        = store_be(r_size, w_lane);
  assign w_wr_data   = store_data(r_size, r_wdata);
  assign w_load_data = load_extract(r_size, w_lane, w_rd_word);
  // Commit only in RESP so a store aborted by reset during WAIT never reaches the RAM.
  assign w_we        = (r_state == DmrResp) && r_write && !w_fault;

  dmem_responder_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk    (clk),
    .i_we   (w_we),
    .i_be   (w_be),
    .i_addr (w_word_idx),
    .i_wdata(w_wr_data),
    .o_rdata(w_rd_word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= DmrIdle;
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_size  <= SizeByte;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        DmrIdle: begin
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          r_rdata <= '0;
          // busy covers the ready cycle, then follows MREQ so a held request re-arms.
          r_busy  <= bus.MREQ;
          if (bus.MREQ) begin
            r_write <= bus.WRITE;
            r_size  <= size_e'(bus.SIZE);
            r_addr  <= bus.addr[ADDR_WIDTH+1:0];
            r_wdata <= bus.wdata;
            r_cnt   <= CntW'(WAIT_CYCLES);
            r_state <= (WAIT_CYCLES == 0) ? DmrResp : DmrWait;
          end
        end
        DmrWait: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt <= CntW'(1)) begin
            r_state <= DmrResp;
          end
        end
        DmrResp: begin
          r_ready <= 1'b1;
          r_err   <= w_fault;
          r_rdata <= (w_fault || r_write) ? 32'h0 : w_load_data;
          r_state <= DmrIdle;
        end
        default: begin
          r_state <= DmrIdle;
        end
      endcase
    end
  end

  assign bus.rdata = r_rdata;
  assign bus.ready = r_ready;
  assign bus.err   = r_err;
  assign bus.busy  = r_busy;

endmodule
